// File: rtl/instruction_memory_sync.sv
// LEGv8 instruction memory: byte array read as big-endian words, one-entry
// registered fetch output with valid/ready, and a word-wide program-load port.
module instruction_memory_sync #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter logic [31:0] FAULT_INSTR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  input  logic                  fetch_req,
  output logic                  fetch_ready,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  instr_fault,
  input  logic                  load_start,
  input  logic                  load_wr_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  input  logic                  load_done,
  output logic                  load_busy,
  output logic [15:0]           load_count,
  output logic                  load_error
);

  localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  // Highest legal word address; compared at full ADDR_WIDTH so nothing wraps.
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state, stateNext;

  logic [7:0] mem [DEPTH_BYTES];

  logic             fetchOk, loadOk, fetchAccept, loadWrite, loadReject;
  logic [IDX_W-1:0] fetchIdx, loadIdx;
  logic [31:0]      readWord;

  assign fetchOk  = (fetch_pc[1:0] == 2'b00) && (fetch_pc <= LAST_WORD);
  assign loadOk   = (load_addr[1:0] == 2'b00) && (load_addr <= LAST_WORD);
  assign fetchIdx = fetchOk ? fetch_pc[IDX_W-1:0] : '0;
  assign loadIdx  = loadOk ? load_addr[IDX_W-1:0] : '0;

  assign readWord = {mem[fetchIdx],
                     mem[fetchIdx + IDX_W'(1)],
                     mem[fetchIdx + IDX_W'(2)],
                     mem[fetchIdx + IDX_W'(3)]};

  assign fetch_ready = (state == RUN) && (!instr_valid || instr_ready);
  assign fetchAccept = fetch_req && fetch_ready;

  // load_start in LOAD restarts the session, so a coincident write is not taken.
  assign loadWrite  = !reset && (state == LOAD) && load_wr_en && !load_start && loadOk;
  assign loadReject = (state == LOAD) && load_wr_en && !load_start && !loadOk;

  always_comb begin
    stateNext = state;
    if (load_start)
      stateNext = LOAD;
    else if (load_done)
      stateNext = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= RUN;
    else
      state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_busy  <= 1'b0;
      load_count <= '0;
      load_error <= 1'b0;
    end else begin
      load_busy <= (stateNext == LOAD);
      if (load_start) begin
        load_count <= '0;
        load_error <= 1'b0;
      end else begin
        if (loadWrite && (load_count != '1))
          load_count <= load_count + 16'd1;
        if (loadReject)
          load_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (loadWrite) begin
      for (int unsigned b = 0; b < 4; b++)
        mem[loadIdx + IDX_W'(b)] <= load_data[31 - 8*b -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
    end else if (fetchAccept) begin
      instr       <= fetchOk ? readWord : FAULT_INSTR;
      instr_valid <= 1'b1;
      instr_fault <= !fetchOk;
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Bench for instruction_memory_sync: behavioural scoreboard checked every cycle
// plus a table of fetch vectors with explicit expected words.
module tb_instruction_memory_sync;

  localparam int unsigned AW    = 64;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] FAULT = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset, fetch_req, fetch_ready, instr_valid, instr_ready, instr_fault;
  logic [AW-1:0] fetch_pc, load_addr;
  logic [31:0]   instr, load_data;
  logic          load_start, load_wr_en, load_done, load_busy, load_error;
  logic [15:0]   load_count;

  instruction_memory_sync #(
    .ADDR_WIDTH (AW),
    .DEPTH_BYTES(DEPTH),
    .FAULT_INSTR(FAULT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_pc   (fetch_pc),
    .fetch_req  (fetch_req),
    .fetch_ready(fetch_ready),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_fault(instr_fault),
    .load_start (load_start),
    .load_wr_en (load_wr_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .load_busy  (load_busy),
    .load_count (load_count),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] mMem [DEPTH/4];
  logic        mLoad, mValid, mFault, mErr, pend;
  logic [31:0] mInstr;
  logic [15:0] mCount;

  function automatic logic addrOk(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && (a <= AW'(DEPTH - 4));
  endfunction

  initial begin
    for (int i = 0; i < DEPTH/4; i++) mMem[i] = '0;
  end

  always @(negedge clk) begin
    logic expReady, acc;
    exp_t e;
    if (reset) begin
      mLoad = 0; mValid = 0; mFault = 0; mErr = 0; pend = 0;
      mInstr = '0; mCount = '0;
      expQ.delete();
    end else begin
      expReady = !mLoad && (!mValid || instr_ready);
      if (pend) begin
        pend = 0;
        if (expQ.size() == 0) begin
          chk("sbUnderflow", 1, 0);
        end else begin
          e = expQ.pop_front();
          mInstr = e.instr;
          mFault = e.fault;
        end
      end
      chk("instrValid", instr_valid, mValid);
      chk("instr", instr, mInstr);
      chk("instrFault", instr_fault, mFault);
      chk("fetchReady", fetch_ready, expReady);
      chk("loadBusy", load_busy, mLoad);
      chk("loadCount", load_count, mCount);
      chk("loadError", load_error, mErr);

      acc = fetch_req && expReady;
      if (acc) begin
        e.fault = !addrOk(fetch_pc);
        e.instr = e.fault ? FAULT : mMem[int'(fetch_pc >> 2)];
        expQ.push_back(e);
        pend = 1;
        mValid = 1;
      end else if (mValid && instr_ready) begin
        mValid = 0;
        mFault = 0;
      end
      if (mLoad && load_wr_en && !load_start) begin
        if (addrOk(load_addr)) begin
          mMem[int'(load_addr >> 2)] = load_data;
          if (mCount != 16'hFFFF) mCount++;
        end else begin
          mErr = 1;
        end
      end
      if (load_start) begin
        mLoad = 1; mCount = '0; mErr = 0;
      end else if (load_done) begin
        mLoad = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
    logic          fault;
  } vec_t;

  vec_t tbl[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ldWord(input logic [AW-1:0] a, input logic [31:0] d);
    load_wr_en = 1; load_addr = a; load_data = d;
    cyc();
    load_wr_en = 0;
  endtask

  task automatic startLoad();
    load_start = 1;
    cyc();
    load_start = 0;
  endtask

  task automatic fetchOne(input logic [AW-1:0] pc);
    fetch_req = 1; fetch_pc = pc; instr_ready = 1;
    cyc();
    fetch_req = 0;
  endtask

  initial begin
    reset = 1; fetch_req = 0; fetch_pc = '0; instr_ready = 0;
    load_start = 0; load_wr_en = 0; load_addr = '0; load_data = '0; load_done = 0;
    tbl = '{
      '{64'd0,                   32'hF842802A, 1'b0},
      '{64'd4,                   32'hCB03804B, 1'b0},
      '{64'd8,                   32'h8B03008C, 1'b0},
      '{64'd12,                  32'hF844802D, 1'b0},
      '{64'd2,                   FAULT,        1'b1},
      '{64'(DEPTH - 4),          32'hD503201F, 1'b0},
      '{64'(DEPTH),              FAULT,        1'b1},
      '{64'(DEPTH - 3),          FAULT,        1'b1},
      '{64'hFFFF_FFFF_FFFF_FFFC, FAULT,        1'b1}
    };
    repeat (2) cyc();
    reset = 0;
    chk("rstInstr", instr, 32'h0);
    chk("rstValid", instr_valid, 0);
    chk("rstBusy", load_busy, 0);

    // Program load
    startLoad();
    chk("busyInLoad", load_busy, 1);
    ldWord(64'd0,  32'hF842802A);
    ldWord(64'd4,  32'hCB03804B);
    ldWord(64'd8,  32'h8B03008C);
    ldWord(64'd12, 32'hF844802D);
    ldWord(64'(DEPTH - 4), 32'hD503201F);
    load_done = 1;
    cyc();
    load_done = 0;
    chk("busyFall", load_busy, 0);
    chk("loadCount5", load_count, 16'd5);
    chk("loadErr0", load_error, 0);

    // Back-to-back fetches and boundary addresses
    for (int i = 0; i < tbl.size(); i++) begin
      fetch_req = 1; fetch_pc = tbl[i].pc; instr_ready = 1;
      cyc();
      chk("tblInstr", instr, tbl[i].instr);
      chk("tblFault", instr_fault, tbl[i].fault);
      chk("tblValid", instr_valid, 1);
    end
    fetch_req = 0;
    cyc();

    // Backpressure: hold, ignored request, accept on the release cycle
    fetch_req = 1; fetch_pc = 64'd4; instr_ready = 0;
    cyc();
    fetch_pc = 64'd8;
    repeat (3) begin
      cyc();
      chk("holdInstr", instr, 32'hCB03804B);
      chk("holdReady", fetch_ready, 0);
    end
    instr_ready = 1;
    cyc();
    chk("releaseInstr", instr, 32'h8B03008C);
    fetch_req = 0;
    cyc();

    // Bad load writes, fetch blocked in LOAD, re-clear on load_start
    startLoad();
    ldWord(64'd16, 32'h1234_5678);
    ldWord(64'd6, 32'hAAAA_AAAA);
    ldWord(64'(DEPTH), 32'hBBBB_BBBB);
    chk("badErr", load_error, 1);
    chk("badCount", load_count, 16'd1);
    fetch_req = 1; fetch_pc = 64'd0;
    cyc();
    chk("noFetchInLoad", instr_valid, 0);
    fetch_req = 0;
    startLoad();
    chk("reclrErr", load_error, 0);
    chk("reclrCount", load_count, 16'd0);
    load_done = 1;
    cyc();
    load_done = 0;
    fetchOne(64'd4);
    chk("memUnchanged", instr, 32'hCB03804B);
    fetchOne(64'd16);
    chk("goodWrite", instr, 32'h1234_5678);
    cyc();

    // Reset in the middle of a load session
    startLoad();
    ldWord(64'd20, 32'hA1A1_0001);
    ldWord(64'd24, 32'hA2A2_0002);
    reset = 1;
    cyc();
    reset = 0;
    chk("midRstBusy", load_busy, 0);
    chk("midRstCount", load_count, 16'd0);
    chk("midRstValid", instr_valid, 0);
    chk("midRstInstr", instr, 32'h0);
    chk("midRstReady", fetch_ready, 1);
    fetchOne(64'd20);
    chk("keptWord20", instr, 32'hA1A1_0001);
    fetchOne(64'd24);
    chk("keptWord24", instr, 32'hA2A2_0002);
    repeat (2) cyc();

    chk("sbDrained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
